robot_seq: RTL and testbench
============================

# robot_seq

Parametrised, program-driven successor to the hard-coded robot controller state machines. It executes a loadable table of control words, one per clock: each word branches or waits on one selected input and drives a full output vector. It also carries a transition-count monitor on one programmable address, which raises an alarm when that address fires more often than a threshold. It sits between the sensor inputs (x) and the actuator command lines (y) and replaces per-benchmark hand-written FSMs.

## Interface
Parameters:
- NX, 5: number of condition inputs.
- NY, 43: number of command outputs.
- DEPTH, 64: program words (power of two); AW = clog2(DEPTH).
- CW, clog2(NX) (min 1): condition-select field width.
- CNT_W, 8: monitor counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- x  in  NX  condition inputs, sampled at each clk edge.
- run  in  1  1 = execute; 0 = pause/re-arm.
- prog_we  in  1  program write strobe.
- prog_addr  in  AW  program write address.
- prog_data  in  2+CW+1+AW+NY  program word {op, sel, pol, tgt, out}.
- y  out  NY  registered command outputs.
- pc  out  AW  current program address.
- halted  out  1  HALT executed.
- mon_addr  in  AW  monitored program address.
- mon_thresh  in  CNT_W  alarm threshold; 0 disables the alarm.
- mon_clr  in  1  synchronous clear of the monitor counter and alarm.
- mon_count  out  CNT_W  saturating fire count.
- mon_alarm  out  1  registered alarm.

## Operation
- Reset state:
  - pc = 0, y = 0, halted = 0, mon_count = 0, mon_alarm = 0.
  - Program memory is not reset.
- Writes: when prog_we = 1 and run = 0, mem[prog_addr] <= prog_data at the clk edge. A write with run = 1 is ignored.
- Condition: cond = (sel < NX ? x[sel] : 0) XOR pol.
- Each cycle with run = 1 and halted = 0, the block executes w = mem[pc]:
  - NEXT (00): y <= w.out; pc <= pc+1.
  - BR (01): if cond, y <= w.out and pc <= w.tgt. Otherwise y <= 0 and pc <= pc+1.
  - WAIT (10): if cond, y <= w.out and pc <= pc+1. Otherwise y <= 0 and pc holds.
  - HALT (11): y <= 0; halted <= 1; pc holds.
- pc+1 wraps from DEPTH-1 to 0.
- When run = 1 and halted = 1: y <= 0 and nothing changes.
- When run = 0: y <= 0. If halted = 1, halted <= 0 and pc <= 0 (re-arm); otherwise pc holds (pause).
- Fire definition: an execution at pc is a fire when it is NEXT, a taken BR, a not-taken BR, or a WAIT with cond = 1. A fire is any execution that changes or advances pc; a stalled WAIT and HALT are not fires.
- Monitor:
  - Each fire with pc == mon_addr increments mon_count, saturating at 2^CNT_W-1.
  - mon_alarm <= (mon_thresh != 0) && (next mon_count >= mon_thresh).
  - mon_clr has priority over an increment in the same cycle: count <= 0, alarm <= 0.
  - A change of mon_addr does not clear the count.

## Timing
- Single-cycle execution: x and mem[pc] are combinational into the next-state logic, and y, pc and halted update at the same edge. y shows the output of the word executed in the previous cycle.
- The first execution happens on the first edge after rst falls with run = 1; y becomes valid one cycle after that edge.
- A memory write is visible to an execution at the next edge.
- mon_alarm asserts on the same edge on which mon_count reaches mon_thresh.
- rst asserted mid-program forces all reset values immediately, independent of clk. Execution resumes from pc = 0 on the first edge after release.

## Structure
- Package robot_seq_pkg holds:
  - the op_t enum (NEXT, BR, WAIT, HALT);
  - field offset/width functions for the word layout;
  - the fire-decode function.
- Sub-module robot_seq_mon holds the counter, saturation, clear and alarm logic. Its inputs are fire, pc, mon_addr, mon_thresh and mon_clr.
- Program memory is a plain register array in robot_seq.

## Test plan
- Reset: load any program, assert rst mid-run -> pc = 0, y = 0, halted = 0, mon_count = 0 immediately; restart executes mem[0].
- Sequence with defaults:
  - Program: word0 = WAIT sel=3 pol=0 out=y13..y15; word1 = NEXT out=y17; word2 = HALT.
  - Hold x4 = 0 for 3 cycles: pc stays 0 and y = 0.
  - Raise x4: y13..y15 set next cycle, then y17, then halted = 1.
- BR both paths: word0 = BR sel=0 tgt=5. With x1 = 1, pc goes to 5; with x1 = 0, pc goes to 1 and y = 0. Repeat with pol = 1 and check the paths swap.
- Wrap and halt re-arm:
  - NEXT at address 63 -> pc = 0.
  - After HALT, drop run for one cycle -> pc = 0 and halted = 0.
- Monitor:
  - mon_addr = 0, mon_thresh = 5, program loops through address 0.
  - Alarm rises on the 5th fire.
  - mon_clr together with a fire -> count = 0.
  - With CNT_W = 3, count saturates at 7.
- Write guard: a prog_we pulse with run = 1 leaves memory unchanged. Check by re-executing the target word.

Source files
------------

// File: rtl/robot_seq_pkg.sv
// Shared types and word-layout helpers for the program-driven robot sequencer.
// Word layout, MSB first: {op[1:0], sel[CW-1:0], pol, tgt[AW-1:0], out[NY-1:0]}.
package robot_seq_pkg;

    typedef enum logic [1:0] {
        OpNext = 2'b00,
        OpBr   = 2'b01,
        OpWait = 2'b10,
        OpHalt = 2'b11
    } op_t;

    function automatic int unsigned tgt_lsb(input int unsigned ny);
        return ny;
    endfunction

    function automatic int unsigned pol_bit(input int unsigned ny, input int unsigned aw);
        return ny + aw;
    endfunction

    function automatic int unsigned sel_lsb(input int unsigned ny, input int unsigned aw);
        return ny + aw + 1;
    endfunction

    function automatic int unsigned op_lsb(input int unsigned ny, input int unsigned aw,
                                           input int unsigned cw);
        return ny + aw + 1 + cw;
    endfunction

    function automatic int unsigned word_w(input int unsigned ny, input int unsigned aw,
                                           input int unsigned cw);
        return ny + aw + cw + 3;
    endfunction

    // A fire is any execution that moves pc; stalled WAIT and HALT do not count.
    function automatic logic is_fire(input op_t op, input logic cond);
        return (op == OpNext) || (op == OpBr) || ((op == OpWait) && cond);
    endfunction

endpackage

// File: rtl/robot_seq_mon.sv
// Saturating fire counter on one program address with a threshold alarm.
module robot_seq_mon
    import robot_seq_pkg::*;
#(
    parameter int unsigned AW    = 6,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             fire_i,
    input  logic [AW-1:0]    pc_i,
    input  logic [AW-1:0]    mon_addr_i,
    input  logic [CNT_W-1:0] mon_thresh_i,
    input  logic             mon_clr_i,
    output logic [CNT_W-1:0] mon_count_o,
    output logic             mon_alarm_o
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q, count_d;
    logic             alarm_q, alarm_d;

    // Next count: clear wins, otherwise saturating increment on a matching fire.
    always_comb begin
        count_d = count_q;
        alarm_d = 1'b0;
        if (mon_clr_i) begin
            count_d = '0;
        end else begin
            if (fire_i && (pc_i == mon_addr_i) && (count_q != CntMax)) begin
                count_d = count_q + CNT_W'(1);
            end
            alarm_d = (mon_thresh_i != '0) && (count_d >= mon_thresh_i);
        end
    end

    // Counter and alarm registers.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            count_q <= count_d;
            alarm_q <= alarm_d;
        end
    end

    assign mon_count_o = count_q;
    assign mon_alarm_o = alarm_q;

endmodule

// File: rtl/robot_seq.sv
// Program-driven controller: executes one control word per clock from a loadable table.
module robot_seq
    import robot_seq_pkg::*;
#(
    parameter int unsigned NX    = 5,
    parameter int unsigned NY    = 43,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CW    = (NX > 1) ? $clog2(NX) : 1,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned WW   = NY + AW + CW + 3
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic [NX-1:0]    x_i,
    input  logic             run_i,
    input  logic             prog_we_i,
    input  logic [AW-1:0]    prog_addr_i,
    input  logic [WW-1:0]    prog_data_i,
    output logic [NY-1:0]    y_o,
    output logic [AW-1:0]    pc_o,
    output logic             halted_o,
    input  logic [AW-1:0]    mon_addr_i,
    input  logic [CNT_W-1:0] mon_thresh_i,
    input  logic             mon_clr_i,
    output logic [CNT_W-1:0] mon_count_o,
    output logic             mon_alarm_o
);

    localparam int unsigned TgtLsb = tgt_lsb(NY);
    localparam int unsigned PolBit = pol_bit(NY, AW);
    localparam int unsigned SelLsb = sel_lsb(NY, AW);
    localparam int unsigned OpLsb  = op_lsb(NY, AW, CW);

    logic [WW-1:0] mem_q [DEPTH];

    logic [NY-1:0] y_q, y_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          halted_q, halted_d;

    logic [WW-1:0] w;
    op_t           w_op;
    logic [CW-1:0] w_sel;
    logic          w_pol;
    logic [AW-1:0] w_tgt;
    logic [NY-1:0] w_out;
    logic [AW-1:0] pc_inc;
    logic          cond_raw, cond;
    logic          fire;

    assign w      = mem_q[pc_q];
    assign w_op   = op_t'(w[OpLsb +: 2]);
    assign w_sel  = w[SelLsb +: CW];
    assign w_pol  = w[PolBit];
    assign w_tgt  = w[TgtLsb +: AW];
    assign w_out  = w[NY-1:0];
    assign pc_inc = pc_q + AW'(1);  // DEPTH is a power of two, so this wraps to 0

    // Program writes only while paused; memory has no reset.
    always_ff @(posedge clk_i) begin
        if (prog_we_i && !run_i) begin
            mem_q[prog_addr_i] <= prog_data_i;
        end
    end

    // Condition select; out-of-range selects read as 0 before polarity.
    always_comb begin
        cond_raw = 1'b0;
        for (int unsigned i = 0; i < NX; i++) begin
            if (w_sel == CW'(i)) begin
                cond_raw = x_i[i];
            end
        end
        cond = cond_raw ^ w_pol;
    end

    // Execute the current word; y drops to 0 whenever the word does not drive it.
    always_comb begin
        y_d      = '0;
        pc_d     = pc_q;
        halted_d = halted_q;
        fire     = 1'b0;
        if (run_i) begin
            if (!halted_q) begin
                fire = is_fire(w_op, cond);
                unique case (w_op)
                    OpNext: begin
                        y_d  = w_out;
                        pc_d = pc_inc;
                    end
                    OpBr: begin
                        if (cond) begin
                            y_d  = w_out;
                            pc_d = w_tgt;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                    OpWait: begin
                        if (cond) begin
                            y_d  = w_out;
                            pc_d = pc_inc;
                        end
                    end
                    OpHalt: halted_d = 1'b1;
                    default: ;
                endcase
            end
        end else if (halted_q) begin
            // Dropping run after HALT re-arms from address 0.
            halted_d = 1'b0;
            pc_d     = '0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            y_q      <= '0;
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            y_q      <= y_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    robot_seq_mon #(
        .AW    (AW),
        .CNT_W (CNT_W)
    ) u_mon (
        .clk_i        (clk_i),
        .rst          (rst),
        .fire_i       (fire),
        .pc_i         (pc_q),
        .mon_addr_i   (mon_addr_i),
        .mon_thresh_i (mon_thresh_i),
        .mon_clr_i    (mon_clr_i),
        .mon_count_o  (mon_count_o),
        .mon_alarm_o  (mon_alarm_o)
    );

    assign y_o      = y_q;
    assign pc_o     = pc_q;
    assign halted_o = halted_q;

endmodule

// File: tb/tb_robot_seq.sv
// Directed bench for robot_seq: a default instance plus a CNT_W = 3 instance on the same inputs.
module tb_robot_seq;
    import robot_seq_pkg::*;

    localparam int NX = 5;
    localparam int NY = 43;
    localparam int AW = 6;
    localparam int CW = 3;
    localparam int WW = NY + AW + CW + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NX-1:0] x = '0;
    logic          run = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [WW-1:0] prog_data = '0;
    logic [AW-1:0] mon_addr = '0;
    logic [7:0]    mon_thresh = '0;
    logic          mon_clr = 1'b0;

    logic [NY-1:0] y, y3;
    logic [AW-1:0] pc, pc3;
    logic          halted, halted3;
    logic [7:0]    mon_count;
    logic [2:0]    mon_count3;
    logic          mon_alarm, mon_alarm3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    robot_seq dut (
        .clk_i        (clk),
        .rst          (rst),
        .x_i          (x),
        .run_i        (run),
        .prog_we_i    (prog_we),
        .prog_addr_i  (prog_addr),
        .prog_data_i  (prog_data),
        .y_o          (y),
        .pc_o         (pc),
        .halted_o     (halted),
        .mon_addr_i   (mon_addr),
        .mon_thresh_i (mon_thresh),
        .mon_clr_i    (mon_clr),
        .mon_count_o  (mon_count),
        .mon_alarm_o  (mon_alarm)
    );

    robot_seq #(.CNT_W(3)) dut3 (
        .clk_i        (clk),
        .rst          (rst),
        .x_i          (x),
        .run_i        (run),
        .prog_we_i    (prog_we),
        .prog_addr_i  (prog_addr),
        .prog_data_i  (prog_data),
        .y_o          (y3),
        .pc_o         (pc3),
        .halted_o     (halted3),
        .mon_addr_i   (mon_addr),
        .mon_thresh_i (mon_thresh[2:0]),
        .mon_clr_i    (mon_clr),
        .mon_count_o  (mon_count3),
        .mon_alarm_o  (mon_alarm3)
    );

    function automatic logic [WW-1:0] mk(input op_t op, input int sel, input logic pol,
                                         input int tgt, input logic [NY-1:0] out);
        return {op, CW'(sel), pol, AW'(tgt), out};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [WW-1:0] d);
        run       = 1'b0;
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = d;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic rpulse();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset values
        #1;
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_count", 64'(mon_count), 64'd0);
        chk("rst_alarm", 64'(mon_alarm), 64'd0);
        rst = 1'b0;

        // WAIT on x[3], NEXT, HALT
        load(0, mk(OpWait, 3, 1'b0, 0, 43'h7000));
        load(1, mk(OpNext, 0, 1'b0, 0, 43'h10000));
        load(2, mk(OpHalt, 0, 1'b0, 0, 43'h0));
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_pc", 64'(pc), 64'd0);
            chk("wait_y", 64'(y), 64'd0);
        end
        x[3] = 1'b1;
        step();
        chk("seq_y0", 64'(y), 64'h7000);
        chk("seq_pc0", 64'(pc), 64'd1);
        step();
        chk("seq_y1", 64'(y), 64'h10000);
        chk("seq_pc1", 64'(pc), 64'd2);
        step();
        chk("halt_y", 64'(y), 64'd0);
        chk("halt_flag", 64'(halted), 64'd1);
        chk("halt_pc", 64'(pc), 64'd2);
        step();
        chk("halted_hold_pc", 64'(pc), 64'd2);
        chk("halted_hold_flag", 64'(halted), 64'd1);
        run = 1'b0;
        step();
        chk("rearm_pc", 64'(pc), 64'd0);
        chk("rearm_halted", 64'(halted), 64'd0);

        // Asynchronous reset mid-run
        run = 1'b1;
        step();
        step();
        chk("mid_pc", 64'(pc), 64'd2);
        chk("mid_count", 64'(mon_count), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_pc", 64'(pc), 64'd0);
        chk("async_y", 64'(y), 64'd0);
        chk("async_count", 64'(mon_count), 64'd0);
        rst = 1'b0;
        step();
        chk("restart_y", 64'(y), 64'h7000);
        chk("restart_pc", 64'(pc), 64'd1);

        // BR on x[0], both polarities
        x = '0;
        load(0, mk(OpBr, 0, 1'b0, 5, 43'h1));
        load(1, mk(OpHalt, 0, 1'b0, 0, 43'h0));
        load(5, mk(OpHalt, 0, 1'b0, 0, 43'h0));
        x[0] = 1'b1;
        rpulse();
        run = 1'b1;
        step();
        chk("br_taken_pc", 64'(pc), 64'd5);
        chk("br_taken_y", 64'(y), 64'h1);
        rpulse();
        x[0] = 1'b0;
        step();
        chk("br_nt_pc", 64'(pc), 64'd1);
        chk("br_nt_y", 64'(y), 64'd0);
        load(0, mk(OpBr, 0, 1'b1, 5, 43'h1));
        rpulse();
        run = 1'b1;
        x[0] = 1'b1;
        step();
        chk("brp_nt_pc", 64'(pc), 64'd1);
        chk("brp_nt_y", 64'(y), 64'd0);
        rpulse();
        x[0] = 1'b0;
        step();
        chk("brp_taken_pc", 64'(pc), 64'd5);
        chk("brp_taken_y", 64'(y), 64'h1);

        // Wrap from 63 and write guard while running
        load(0, mk(OpBr, 7, 1'b1, 63, 43'h2));
        load(63, mk(OpNext, 0, 1'b0, 0, 43'h4));
        rpulse();
        run = 1'b1;
        step();
        chk("jump63_pc", 64'(pc), 64'd63);
        chk("jump63_y", 64'(y), 64'h2);
        step();
        chk("wrap_pc", 64'(pc), 64'd0);
        chk("wrap_y", 64'(y), 64'h4);
        prog_we   = 1'b1;
        prog_addr = AW'(63);
        prog_data = mk(OpHalt, 0, 1'b0, 0, 43'h0);
        step();
        prog_we = 1'b0;
        chk("guard_pc63", 64'(pc), 64'd63);
        step();
        chk("guard_pc", 64'(pc), 64'd0);
        chk("guard_y", 64'(y), 64'h4);
        chk("guard_halted", 64'(halted), 64'd0);

        // Monitor: address 0 fires every cycle
        load(0, mk(OpBr, 7, 1'b1, 0, 43'h8));
        mon_addr   = '0;
        mon_thresh = 8'd5;
        rpulse();
        run = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("mon_count", 64'(mon_count), 64'(i));
            chk("mon_alarm", 64'(mon_alarm), 64'(i >= 5));
            chk("mon_count3", 64'(mon_count3), 64'((i > 7) ? 7 : i));
            chk("mon_alarm3", 64'(mon_alarm3), 64'(i >= 5));
        end
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
        chk("clr_count", 64'(mon_count), 64'd0);
        chk("clr_alarm", 64'(mon_alarm), 64'd0);
        chk("clr_count3", 64'(mon_count3), 64'd0);
        step();
        chk("post_clr_count", 64'(mon_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
